uart_tx_fifo: RTL and testbench

Second-generation UART transmitter with a parametrised transmit FIFO, programmable oversample ratio and up to MAX_DATA_W data bits. It supports 1, 1.5 or 2 stop bits, even/odd/mark/space parity and CTS flow control. Frame configuration is latched per frame, so software can reprogram it while the FIFO drains. It sits between the register/bus interface and the tx pad, driven by the shared baud tick generator.

---
 rtl/uart_pkg.sv | 53 +++++
 rtl/uart_sync_fifo.sv | 84 ++++++++
 rtl/uart_tx_fifo.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter: FSM states, parity modes,
// stop-bit encodings and the parity helper used by the frame datapath.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } tx_state_t;

  typedef enum logic [1:0] {
    PAR_EVEN  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_MARK  = 2'b10,
    PAR_SPACE = 2'b11
  } parity_mode_t;

  localparam logic [1:0] STOP_1     = 2'b00;
  localparam logic [1:0] STOP_1P5   = 2'b01;
  localparam logic [1:0] STOP_2     = 2'b10;
  localparam logic [1:0] STOP_2_ALT = 2'b11;

  localparam logic [3:0] DATA_BITS_MIN = 4'd5;

  function automatic logic parity_bit(input parity_mode_t mode, input logic acc);
    logic p;
    case (mode)
      PAR_EVEN:  p = acc;
      PAR_ODD:   p = ~acc;
      PAR_MARK:  p = 1'b1;
      PAR_SPACE: p = 1'b0;
      default:   p = acc;
    endcase
    return p;
  endfunction

  // Out-of-range requests saturate to the supported character sizes.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] req, input logic [3:0] max_bits);
    logic [3:0] n;
    if (req < DATA_BITS_MIN) begin
      n = DATA_BITS_MIN;
    end else if (req > max_bits) begin
      n = max_bits;
    end else begin
      n = req;
    end
    return n;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full/empty/level flags; writes while full and
// reads while empty are ignored. Synchronous active-high reset empties it.
module uart_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_s, pop_s;

  assign push_s = push_i & ~full_q;
  assign pop_s  = pop_i & ~empty_q;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-fed UART transmitter with per-frame latched configuration and CTS gating.
// Optional break generation is enabled by defining UART_TX_BREAK_EN.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int OVS        = 16,
  parameter int MAX_DATA_W = 9,
  localparam int LW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [MAX_DATA_W-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [3:0]            data_bits,
  input  logic [1:0]            stop_bits,
  input  logic                  parity_en,
  input  logic [1:0]            parity_mode,
  input  logic                  cts_n,
  input  logic                  send_break,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic [LW-1:0]         fifo_level
);

  localparam int CW = $clog2(2 * OVS);
  localparam logic [CW-1:0] LAST_1   = CW'(OVS - 1);
  localparam logic [CW-1:0] LAST_1P5 = CW'(OVS + OVS / 2 - 1);
  localparam logic [CW-1:0] LAST_2   = CW'(2 * OVS - 1);
  localparam logic [3:0]    MAX_BITS = 4'(MAX_DATA_W);

  tx_state_t             state_q, state_d;
  logic [CW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [MAX_DATA_W-1:0] shift_q, shift_d;
  logic                  par_acc_q, par_acc_d;
  logic [3:0]            dbits_q, dbits_d;
  logic [1:0]            stop_q, stop_d;
  logic                  par_en_q, par_en_d;
  parity_mode_t          par_mode_q, par_mode_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  busy_q;

  logic                  load_s, pop_s, done_set_s;
  logic                  start_ok_s, bit_last_s, stop_last_s;
  logic [CW-1:0]         stop_end_s;
  logic [MAX_DATA_W-1:0] fifo_head_s;
  logic                  fifo_full_s, fifo_empty_s;

`ifdef UART_TX_BREAK_EN
  // Minimum break: one full frame at the widest character with parity and one stop bit.
  localparam int BRK_MIN = OVS * (MAX_DATA_W + 3);
  localparam int BW      = $clog2(BRK_MIN);
  localparam logic [BW-1:0] BRK_LAST = BW'(BRK_MIN - 1);
  logic [BW-1:0] brk_cnt_q, brk_cnt_d;
  logic          brk_stop_q, brk_stop_d;
`else
  logic unused_break_s;
  assign unused_break_s = send_break;
`endif

  uart_sync_fifo #(
    .WIDTH (MAX_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_valid & wr_ready),
    .pop_i   (pop_s),
    .wdata_i (wr_data),
    .rdata_o (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .level_o (fifo_level)
  );

  assign wr_ready    = ~fifo_full_s;
  assign start_ok_s  = ~fifo_empty_s & ~cts_n;
  assign bit_last_s  = (tick_cnt_q == LAST_1);
  assign stop_last_s = (tick_cnt_q == stop_end_s);

  // Final tick index of the latched stop period.
  always_comb begin
    case (stop_q)
      STOP_1:             stop_end_s = LAST_1;
      STOP_1P5:           stop_end_s = LAST_1P5;
      STOP_2, STOP_2_ALT: stop_end_s = LAST_2;
      default:            stop_end_s = LAST_2;
    endcase
  end

  // Next-state and datapath update; everything advances only on tick.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_acc_d  = par_acc_q;
    dbits_d    = dbits_q;
    stop_d     = stop_q;
    par_en_d   = par_en_q;
    par_mode_d = par_mode_q;
    load_s     = 1'b0;
    pop_s      = 1'b0;
    done_set_s = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_cnt_d  = brk_cnt_q;
    brk_stop_d = brk_stop_q;
`endif
    if (tick) begin
      case (state_q)
        ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (send_break) begin
            state_d    = ST_BREAK;
            tick_cnt_d = '0;
            brk_cnt_d  = '0;
            brk_stop_d = 1'b0;
          end else if (start_ok_s) begin
            load_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
`else
          if (start_ok_s) begin
            load_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
`endif
        end
        ST_START: begin
          if (bit_last_s) begin
            state_d    = ST_DATA;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_last_s) begin
            tick_cnt_d = '0;
            par_acc_d  = par_acc_q ^ shift_q[0];
            shift_d    = shift_q >> 1;
            if (bit_cnt_q == dbits_q - 4'd1) begin
              state_d = par_en_q ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_last_s) begin
            state_d    = ST_STOP;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (stop_last_s) begin
            done_set_s = 1'b1;
            if (start_ok_s) begin
              load_s = 1'b1;
            end else begin
              state_d    = ST_IDLE;
              tick_cnt_d = '0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
`ifdef UART_TX_BREAK_EN
        ST_BREAK: begin
          if (brk_stop_q) begin
            if (bit_last_s) begin
              state_d    = ST_IDLE;
              tick_cnt_d = '0;
              brk_stop_d = 1'b0;
            end else begin
              tick_cnt_d = tick_cnt_q + 1'b1;
            end
          end else if (!send_break && (brk_cnt_q == BRK_LAST)) begin
            brk_stop_d = 1'b1;
            tick_cnt_d = '0;
          end else if (brk_cnt_q != BRK_LAST) begin
            brk_cnt_d = brk_cnt_q + 1'b1;
          end else begin
            brk_cnt_d = brk_cnt_q;
          end
        end
`endif
        default: begin
          state_d    = ST_IDLE;
          tick_cnt_d = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Frame start: pop the head and snapshot the configuration for this frame.
    if (load_s) begin
      pop_s      = 1'b1;
      state_d    = ST_START;
      tick_cnt_d = '0;
      bit_cnt_d  = '0;
      par_acc_d  = 1'b0;
      shift_d    = fifo_head_s;
      dbits_d    = clamp_data_bits(data_bits, MAX_BITS);
      stop_d     = stop_bits;
      par_en_d   = parity_en;
      par_mode_d = parity_mode_t'(parity_mode);
    end else begin
      pop_s = 1'b0;
    end
  end

  // Line level and done pulse for the state being entered.
  always_comb begin
    done_d = done_set_s;
    case (state_d)
      ST_IDLE:   tx_d = 1'b1;
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_bit(par_mode_d, par_acc_d);
      ST_STOP:   tx_d = 1'b1;
`ifdef UART_TX_BREAK_EN
      ST_BREAK:  tx_d = brk_stop_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      dbits_q    <= DATA_BITS_MIN;
      stop_q     <= STOP_1;
      par_en_q   <= 1'b0;
      par_mode_q <= PAR_EVEN;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_cnt_q  <= '0;
      brk_stop_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_acc_q  <= par_acc_d;
      dbits_q    <= dbits_d;
      stop_q     <= stop_d;
      par_en_q   <= par_en_d;
      par_mode_q <= par_mode_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      busy_q     <= (state_d != ST_IDLE);
`ifdef UART_TX_BREAK_EN
      brk_cnt_q  <= brk_cnt_d;
      brk_stop_q <= brk_stop_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: each accepted write queues the expected
// tick-by-tick line pattern, and a monitor compares frames as they appear on tx.
module tb_uart_tx_fifo;

  localparam int OVS = 16;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, tick, wr_valid, wr_ready, parity_en, cts_n, send_break;
  logic [8:0] wr_data;
  logic [3:0] data_bits;
  logic [1:0] stop_bits, parity_mode;
  logic       tx, tx_busy, tx_done;
  logic [3:0] fifo_level;

  typedef struct {
    logic [255:0] pat;
    int           len;
  } frame_t;

  frame_t sb[$];
  frame_t cur;
  int     k;
  logic   in_frame = 1'b0;
  logic   tick_en = 1'b0;
  int     div = 0;
  int     checks = 0;
  int     errors = 0;
  int     done_seen = 0;
  int     gap_cnt = 0;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .OVS(OVS), .MAX_DATA_W(9)) dut (
    .clk(clk), .rst(rst), .tick(tick), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .data_bits(data_bits), .stop_bits(stop_bits),
    .parity_en(parity_en), .parity_mode(parity_mode), .cts_n(cts_n),
    .send_break(send_break), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic frame_t mk_frame(input logic [8:0] d, input logic [3:0] db,
                                      input logic [1:0] sbits, input logic pe, input logic [1:0] pm);
    frame_t f;
    int     n, t, st;
    logic   x, pb;
    n = (db < 4'd5) ? 5 : ((db > 4'd9) ? 9 : int'(db));
    f.pat = '1;
    t = 0;
    x = 1'b0;
    for (int i = 0; i < OVS; i++) begin f.pat[t] = 1'b0; t++; end
    for (int b = 0; b < n; b++) begin
      x = x ^ d[b];
      for (int i = 0; i < OVS; i++) begin f.pat[t] = d[b]; t++; end
    end
    if (pe) begin
      case (pm)
        2'b00:   pb = x;
        2'b01:   pb = ~x;
        2'b10:   pb = 1'b1;
        default: pb = 1'b0;
      endcase
      for (int i = 0; i < OVS; i++) begin f.pat[t] = pb; t++; end
    end
    st = (sbits == 2'b00) ? OVS : ((sbits == 2'b01) ? OVS + OVS / 2 : 2 * OVS);
    for (int i = 0; i < st; i++) begin f.pat[t] = 1'b1; t++; end
    f.len = t;
    return f;
  endfunction

  // Tick generator: one clk wide, every third clk while enabled.
  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tick = (tick_en && div == 2);
      div = (div == 2) ? 0 : div + 1;
    end
  end

  // Line monitor: tick-accurate comparison against the head of the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        in_frame = 1'b0;
        sb.delete();
      end else begin
        if (tick) begin
          if (in_frame) begin
            k = k + 1;
            if (k == cur.len) begin
              chk("tx_done_at_frame_end", tx_done, 1);
              in_frame = 1'b0;
            end else begin
              chk("tx_bit", tx, cur.pat[k]);
            end
          end
          if (!in_frame) begin
            if (tx == 1'b0) begin
              if (sb.size() == 0) begin
                chk("unexpected_start", tx, 1);
              end else begin
                cur = sb.pop_front();
                in_frame = 1'b1;
                k = 0;
              end
            end else if (sb.size() != 0) begin
              gap_cnt++;
            end
          end
        end
        if (tx_done) done_seen++;
      end
    end
  end

  task automatic push_word(input logic [8:0] d, input logic acc);
    @(negedge clk);
    wr_data  = d;
    wr_valid = 1'b1;
    chk("wr_ready_before_push", wr_ready, acc);
    if (acc) sb.push_back(mk_frame(d, data_bits, stop_bits, parity_en, parity_mode));
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_clk);
    int n = 0;
    while ((sb.size() != 0 || in_frame) && n < max_clk) begin
      @(posedge clk); #2;
      n++;
    end
    chk("idle_within_budget", (n < max_clk), 1);
  endtask

  task automatic wait_ticks(input int nt);
    int c = 0;
    int n = 0;
    while (c < nt && n < 10 * nt + 10) begin
      @(posedge clk); #2;
      n++;
      if (tick) c++;
    end
    chk("ticks_within_budget", (c == nt), 1);
  endtask

  task automatic set_cfg(input logic [3:0] db, input logic [1:0] sbits, input logic pe, input logic [1:0] pm);
    data_bits = db; stop_bits = sbits; parity_en = pe; parity_mode = pm;
  endtask

  initial begin
    int d0, g0;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; cts_n = 1'b0; send_break = 1'b0;
    set_cfg(4'd8, 2'b00, 1'b0, 2'b00);
    repeat (3) @(posedge clk);
    #2;
    chk("reset_tx", tx, 1);
    chk("reset_busy", tx_busy, 0);
    chk("reset_done", tx_done, 0);
    chk("reset_level", fifo_level, 0);
    chk("reset_wr_ready", wr_ready, 1);
    @(negedge clk); rst = 1'b0;

    // 8N1 0xA5, config scrambled once the frame has started.
    tick_en = 1'b1;
    d0 = done_seen;
    push_word(9'h0A5, 1'b1);
    begin
      int n = 0;
      while (!in_frame && n < 200) begin @(posedge clk); #2; n++; end
      chk("frame_started", in_frame, 1);
    end
    set_cfg(4'd5, 2'b10, 1'b1, 2'b01);
    wait_idle(2000);
    chk("8n1_done_count", done_seen - d0, 1);
    chk("8n1_busy_after", tx_busy, 0);

    // 7 data bits, odd parity, 2 stop bits.
    set_cfg(4'd7, 2'b10, 1'b1, 2'b01);
    d0 = done_seen;
    push_word(9'h003, 1'b1);
    wait_idle(2000);
    chk("7o2_done_count", done_seen - d0, 1);

    // Out-of-range data_bits saturates to 9.
    set_cfg(4'd15, 2'b00, 1'b0, 2'b00);
    d0 = done_seen;
    push_word(9'h1A5, 1'b1);
    wait_idle(2000);
    chk("9bit_done_count", done_seen - d0, 1);

    // Fill past full with ticks stopped, then drain back-to-back.
    tick_en = 1'b0;
    set_cfg(4'd8, 2'b00, 1'b0, 2'b00);
    repeat (4) @(posedge clk);
    for (int i = 0; i < 9; i++) push_word({i[0], 8'(i * 37 + 5)}, (i < DEPTH));
    #2;
    chk("full_level", fifo_level, DEPTH);
    chk("full_wr_ready", wr_ready, 0);
    d0 = done_seen;
    g0 = gap_cnt;
    tick_en = 1'b1;
    wait_idle(9000);
    chk("burst_done_count", done_seen - d0, DEPTH);
    chk("burst_idle_gaps", gap_cnt - g0, 0);
    chk("burst_level_after", fifo_level, 0);
    chk("burst_wr_ready_after", wr_ready, 1);

    // CTS hold-off, then release, then deassert mid-frame.
    cts_n = 1'b1;
    d0 = done_seen;
    push_word(9'h055, 1'b1);
    wait_ticks(50);
    chk("cts_hold_tx", tx, 1);
    chk("cts_hold_level", fifo_level, 1);
    chk("cts_hold_busy", tx_busy, 0);
    @(negedge clk); cts_n = 1'b0;
    begin
      int n = 0;
      do begin @(posedge clk); #2; n++; end while (!tick && n < 20);
      chk("cts_release_start_bit", tx, 0);
    end
    wait_ticks(40);
    cts_n = 1'b1;
    wait_idle(2000);
    chk("cts_mid_frame_done", done_seen - d0, 1);
    cts_n = 1'b0;

    // 5 data bits, mark parity, 1.5 stop bits.
    set_cfg(4'd5, 2'b01, 1'b1, 2'b10);
    d0 = done_seen;
    push_word(9'h01F, 1'b1);
    wait_idle(2000);
    chk("5m1p5_done_count", done_seen - d0, 1);

    // Reset in the middle of a data bit with a second word queued.
    tick_en = 1'b0;
    set_cfg(4'd8, 2'b00, 1'b0, 2'b00);
    push_word(9'h0F0, 1'b1);
    push_word(9'h00F, 1'b1);
    #2;
    chk("pre_reset_level", fifo_level, 2);
    tick_en = 1'b1;
    wait_ticks(40);
    chk("pre_reset_busy", tx_busy, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #2;
    chk("midframe_reset_tx", tx, 1);
    chk("midframe_reset_level", fifo_level, 0);
    chk("midframe_reset_busy", tx_busy, 0);
    @(negedge clk); rst = 1'b0;
    wait_ticks(20);
    chk("after_reset_tx_idle", tx, 1);
    chk("after_reset_level", fifo_level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1, "timeout");
  end

endmodule
